// File: rtl/noc_local_injector_if.sv
// noc_local_injector_if: request, payload and router-facing flit signals of the local-port injector.
interface noc_local_injector_if #(
    parameter int Width  = 66,
    parameter int MaxLen = 16
);
    localparam int LenW = $clog2(MaxLen + 1);

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_dst_x;
    logic [2:0]       req_dst_y;
    logic [4:0]       req_msg;
    logic [LenW-1:0]  req_len;
    logic             pld_valid;
    logic             pld_ready;
    logic [Width-3:0] pld_data;
    logic [Width-1:0] data_out;
    logic             data_void_out;
    logic             stop_in;

    // slave is the injector itself; master is the tile queues plus the router stop line
    modport slave (
        input  req_valid, req_dst_x, req_dst_y, req_msg, req_len,
        input  pld_valid, pld_data, stop_in,
        output req_ready, pld_ready, data_out, data_void_out
    );

    modport master (
        output req_valid, req_dst_x, req_dst_y, req_msg, req_len,
        output pld_valid, pld_data, stop_in,
        input  req_ready, pld_ready, data_out, data_void_out
    );
endinterface

// File: rtl/noc_local_injector.sv
// noc_local_injector: turns a packet request plus payload stream into head/payload flits for the router local port.
// Optional perf counters are built only when NOC_LOCAL_INJECTOR_PERF_EN is defined.
module noc_local_injector #(
    parameter int Width  = 66,
    parameter int MaxLen = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          CONST_localx,
    input  logic [2:0]          CONST_localy,
    noc_local_injector_if.slave bus,
    output logic                busy,
    output logic [31:0]         perf_pkts,
    output logic [31:0]         perf_stalls
);
    localparam int LenW = $clog2(MaxLen + 1);
    localparam int HdrW = 17;

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t          state;
    logic [LenW-1:0] remaining;
    logic [LenW-1:0] len_clamped;
    logic            xfer;
    logic            open_slot;
    logic            req_fire;
    logic            pld_fire;

    // the output register can take a new flit when it is empty or its flit leaves this cycle
    assign xfer        = !bus.data_void_out && !bus.stop_in;
    assign open_slot   = bus.data_void_out || !bus.stop_in;
    assign bus.req_ready = rst && state == IDLE && open_slot;
    assign bus.pld_ready = state == PAYLOAD && open_slot;
    assign req_fire    = bus.req_valid && bus.req_ready;
    assign pld_fire    = bus.pld_valid && bus.pld_ready;
    assign len_clamped = (bus.req_len > LenW'(MaxLen)) ? LenW'(MaxLen) : bus.req_len;
    assign busy        = state != IDLE || !bus.data_void_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            remaining         <= '0;
            bus.data_out      <= '0;
            bus.data_void_out <= 1'b1;
        end else if (req_fire) begin
            bus.data_out      <= {1'b1, len_clamped == '0, CONST_localy, CONST_localx,
                                  bus.req_dst_y, bus.req_dst_x, bus.req_msg, {(Width-2-HdrW){1'b0}}};
            bus.data_void_out <= 1'b0;
            remaining         <= len_clamped;
            state             <= (len_clamped == '0) ? IDLE : PAYLOAD;
        end else if (pld_fire) begin
            bus.data_out      <= {1'b0, remaining == LenW'(1), bus.pld_data};
            bus.data_void_out <= 1'b0;
            remaining         <= remaining - LenW'(1);
            state             <= (remaining == LenW'(1)) ? IDLE : PAYLOAD;
        end else if (xfer) begin
            bus.data_void_out <= 1'b1;
        end
    end

`ifdef NOC_LOCAL_INJECTOR_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_pkts   <= '0;
            perf_stalls <= '0;
        end else begin
            perf_pkts   <= perf_pkts + 32'(xfer && bus.data_out[Width-2]);
            perf_stalls <= perf_stalls + 32'(!bus.data_void_out && bus.stop_in);
        end
    end
`else
    assign perf_pkts   = '0;
    assign perf_stalls = '0;
`endif
endmodule

// File: tb/tb_noc_local_injector.sv
// tb_noc_local_injector: directed checks of flit format, flow control, back-to-back packets, reset and length clamping.
module tb_noc_local_injector;
    localparam int Width  = 66;
    localparam int MaxLen = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  localx = 3'd1;
    logic [2:0]  localy = 3'd2;
    logic        busy;
    logic [31:0] perf_pkts;
    logic [31:0] perf_stalls;
    logic [63:0] w [4];
    logic [63:0] base;
    int          checks = 0;
    int          errors = 0;

    noc_local_injector_if #(.Width(Width), .MaxLen(MaxLen)) bus ();

    noc_local_injector #(.Width(Width), .MaxLen(MaxLen)) dut (
        .clk(clk),
        .rst(rst),
        .CONST_localx(localx),
        .CONST_localy(localy),
        .bus(bus.slave),
        .busy(busy),
        .perf_pkts(perf_pkts),
        .perf_stalls(perf_stalls)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, {65'd0, obs}, {65'd0, exp});
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic request(input logic [2:0] dx, input logic [2:0] dy, input logic [4:0] msg, input logic [4:0] len);
        bus.req_valid = 1'b1;
        bus.req_dst_x = dx;
        bus.req_dst_y = dy;
        bus.req_msg   = msg;
        bus.req_len   = len;
    endtask

    function automatic logic [65:0] head(input logic [2:0] dx, input logic [2:0] dy, input logic [4:0] msg, input logic tail);
        return {1'b1, tail, localy, localx, dy, dx, msg, 47'd0};
    endfunction

    initial begin
        w[0] = 64'h0123_4567_89AB_CDEF;
        w[1] = 64'hFEDC_BA98_7654_3210;
        w[2] = 64'hDEAD_BEEF_0000_0001;
        w[3] = 64'h8000_0000_0000_0003;
        base = 64'hA000_0000_0000_0000;
        bus.req_valid = 1'b0;
        bus.req_dst_x = '0;
        bus.req_dst_y = '0;
        bus.req_msg   = '0;
        bus.req_len   = '0;
        bus.pld_valid = 1'b0;
        bus.pld_data  = '0;
        bus.stop_in   = 1'b0;

        repeat (2) step();
        chk1("rst_void", bus.data_void_out, 1'b1);
        chk("rst_data", bus.data_out, 66'd0);
        chk1("rst_req_ready", bus.req_ready, 1'b0);
        chk1("rst_pld_ready", bus.pld_ready, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_perf_pkts", 66'(perf_pkts), 66'd0);
        rst = 1'b1;

        // single-flit packet
        request(3'd3, 3'd0, 5'd5, 5'd0);
        settle();
        chk1("t1_req_ready", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
        chk("t1_head", bus.data_out, head(3'd3, 3'd0, 5'd5, 1'b1));
        chk("t1_hdr_bits", 66'(bus.data_out[65:47]), 66'(19'b11_010_001_000_011_00101));
        chk1("t1_void", bus.data_void_out, 1'b0);
        chk1("t1_busy", busy, 1'b1);
        step();
        chk1("t1_void_after", bus.data_void_out, 1'b1);
        chk1("t1_busy_after", busy, 1'b0);

        // 4-payload packet, no back-pressure
        request(3'd2, 3'd1, 5'd9, 5'd4);
        bus.pld_valid = 1'b1;
        bus.pld_data  = w[0];
        settle();
        chk1("t2_pld_ready_idle", bus.pld_ready, 1'b0);
        step();
        bus.req_valid = 1'b0;
        chk("t2_head", bus.data_out, head(3'd2, 3'd1, 5'd9, 1'b0));
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("t2_pld_ready", bus.pld_ready, 1'b1);
            chk1("t2_req_ready_payload", bus.req_ready, 1'b0);
            step();
            chk("t2_flit", bus.data_out, {1'b0, i == 3, w[i]});
            chk1("t2_void", bus.data_void_out, 1'b0);
            if (i < 3) bus.pld_data = w[i+1];
            else bus.pld_valid = 1'b0;
        end
        step();
        chk1("t2_void_after", bus.data_void_out, 1'b1);
        chk1("t2_busy_after", busy, 1'b0);

        // same packet with a 3-cycle stall on payload flit 2
        request(3'd2, 3'd1, 5'd9, 5'd4);
        bus.pld_valid = 1'b1;
        bus.pld_data  = w[0];
        step();
        bus.req_valid = 1'b0;
        chk("t3_head", bus.data_out, head(3'd2, 3'd1, 5'd9, 1'b0));
        step();
        chk("t3_p0", bus.data_out, {2'b00, w[0]});
        bus.pld_data = w[1];
        step();
        chk("t3_p1", bus.data_out, {2'b00, w[1]});
        bus.pld_data = w[2];
        bus.stop_in  = 1'b1;
        settle();
        chk1("t3_pld_ready_stall", bus.pld_ready, 1'b0);
        repeat (3) begin
            step();
            chk("t3_hold", bus.data_out, {2'b00, w[1]});
            chk1("t3_hold_void", bus.data_void_out, 1'b0);
            chk1("t3_hold_pld_ready", bus.pld_ready, 1'b0);
            chk1("t3_hold_busy", busy, 1'b1);
        end
        bus.stop_in = 1'b0;
        settle();
        chk1("t3_pld_ready_resume", bus.pld_ready, 1'b1);
        step();
        chk("t3_p2", bus.data_out, {2'b00, w[2]});
        bus.pld_data = w[3];
        step();
        chk("t3_p3", bus.data_out, {2'b01, w[3]});
        bus.pld_valid = 1'b0;
        step();
        chk1("t3_void_after", bus.data_void_out, 1'b1);
`ifdef NOC_LOCAL_INJECTOR_PERF_EN
        chk("t3_perf_stalls", 66'(perf_stalls), 66'd3);
        chk("t3_perf_pkts", 66'(perf_pkts), 66'd3);
`else
        chk("t3_perf_stalls", 66'(perf_stalls), 66'd0);
        chk("t3_perf_pkts", 66'(perf_pkts), 66'd0);
`endif

        // clear counters, then two back-to-back packets (len 2, len 0)
        rst = 1'b0;
        settle();
        rst = 1'b1;
        request(3'd1, 3'd1, 5'd3, 5'd2);
        bus.pld_valid = 1'b1;
        bus.pld_data  = w[2];
        step();
        chk("t4_head_a", bus.data_out, head(3'd1, 3'd1, 5'd3, 1'b0));
        step();
        chk("t4_a0", bus.data_out, {2'b00, w[2]});
        bus.pld_data = w[3];
        step();
        chk("t4_a1_tail", bus.data_out, {2'b01, w[3]});
        bus.pld_valid = 1'b0;
        request(3'd2, 3'd3, 5'd7, 5'd0);
        settle();
        chk1("t4_req_ready_tail", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
        chk("t4_head_b", bus.data_out, head(3'd2, 3'd3, 5'd7, 1'b1));
        chk1("t4_head_b_void", bus.data_void_out, 1'b0);
        step();
        chk1("t4_void_after", bus.data_void_out, 1'b1);
`ifdef NOC_LOCAL_INJECTOR_PERF_EN
        chk("t4_perf_pkts", 66'(perf_pkts), 66'd2);
`else
        chk("t4_perf_pkts", 66'(perf_pkts), 66'd0);
`endif

        // asynchronous reset mid-payload
        request(3'd1, 3'd3, 5'd2, 5'd4);
        bus.pld_valid = 1'b1;
        bus.pld_data  = w[0];
        step();
        bus.req_valid = 1'b0;
        step();
        chk1("t5_busy_pre", busy, 1'b1);
        rst = 1'b0;
        settle();
        chk1("t5_void", bus.data_void_out, 1'b1);
        chk1("t5_busy", busy, 1'b0);
        chk("t5_data", bus.data_out, 66'd0);
        chk1("t5_req_ready", bus.req_ready, 1'b0);
        chk1("t5_pld_ready", bus.pld_ready, 1'b0);
        rst = 1'b1;
        bus.pld_valid = 1'b0;
        request(3'd0, 3'd7, 5'd31, 5'd0);
        settle();
        chk1("t5_req_ready_after", bus.req_ready, 1'b1);
        step();
        bus.req_valid = 1'b0;
        chk("t5_head", bus.data_out, head(3'd0, 3'd7, 5'd31, 1'b1));
        step();
        chk1("t5_void_after", bus.data_void_out, 1'b1);

        // oversized length clamps to MaxLen payload flits
        request(3'd4, 3'd5, 5'd17, 5'd19);
        bus.pld_valid = 1'b1;
        bus.pld_data  = base;
        step();
        bus.req_valid = 1'b0;
        chk("t6_head", bus.data_out, head(3'd4, 3'd5, 5'd17, 1'b0));
        for (int i = 0; i < 16; i++) begin
            step();
            chk("t6_flit", bus.data_out, {1'b0, i == 15, base + 64'(i)});
            chk1("t6_void", bus.data_void_out, 1'b0);
            bus.pld_data = base + 64'(i + 1);
        end
        settle();
        chk1("t6_pld_ready_idle", bus.pld_ready, 1'b0);
        chk1("t6_req_ready_idle", bus.req_ready, 1'b1);
        step();
        chk1("t6_void_after", bus.data_void_out, 1'b1);
        chk1("t6_busy_after", busy, 1'b0);
        bus.pld_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
